booth_mult_sequencer: RTL and testbench

Upstream operand sequencer for the signed Booth multiplier FSM.
- Buffers signed operand pairs in a small FIFO.
- Issues one-cycle start pulses to the multiplier and waits for its completion.
- Captures the product and presents it downstream on a valid/ready interface.
Lets producers stream operands without tracking the multiplier's handshake.

---
 rtl/booth_mult_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_booth_mult_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sequencer.sv
// Operand sequencer in front of a signed Booth multiplier: buffers operand pairs, issues start
// pulses, waits for completion and holds the product on a valid/ready output. Optional watchdog via BOOTH_SEQ_TIMEOUT_EN.
module booth_mult_sequencer #(
  parameter int WIDTH          = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_x,
  output logic [WIDTH-1:0]     mul_y,
  input  logic [2*WIDTH-1:0]   mul_z,
  input  logic                 mul_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic [WIDTH-1:0]     out_x,
  output logic [WIDTH-1:0]     out_y,
`ifdef BOOTH_SEQ_TIMEOUT_EN
  output logic                 err_timeout,
`endif
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("booth_mult_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // state    | meaning
  // ST_IDLE  | waiting for an operand pair in the FIFO
  // ST_ISSUE | mul_start asserted for this single cycle
  // ST_WAIT  | waiting for the rising edge of mul_valid
  // ST_HOLD  | result presented until out_ready
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   mul_start_q;
  logic [WIDTH-1:0]       mul_x_q, mul_y_q;
  logic                   out_valid_q;
  logic [2*WIDTH-1:0]     out_z_q;
  logic [WIDTH-1:0]       out_x_q, out_y_q;
  logic                   mul_valid_q;

  logic [2*WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic                   fifo_empty, fifo_full, push, pop, mul_done;
  logic [2*WIDTH-1:0]     head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];
  assign mul_done   = mul_valid && !mul_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic [TW-1:0] wait_cnt_q;
  logic          err_timeout_q;
  assign err_timeout = err_timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mul_start_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      mul_valid_q <= 1'b0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      mul_valid_q <= mul_valid;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mul_x_q     <= head[2*WIDTH-1:WIDTH];
            mul_y_q     <= head[WIDTH-1:0];
            mul_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mul_start_q <= 1'b0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
          wait_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
`endif
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Only a fresh rising edge counts; a level left over from the previous op is ignored.
          if (mul_done) begin
            out_z_q     <= mul_z;
            out_x_q     <= mul_x_q;
            out_y_q     <= mul_y_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
`ifdef BOOTH_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == '0) begin
            err_timeout_q <= 1'b1;
            out_z_q       <= '0;
            out_x_q       <= mul_x_q;
            out_y_q       <= mul_y_q;
            out_valid_q   <= 1'b1;
            state_q       <= ST_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q - TW'(1);
          end
`endif
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = !fifo_full;
  assign mul_start = mul_start_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed, table-driven bench for booth_mult_sequencer with a behavioural fixed-latency multiplier.
// Timeout checks are compiled in when BOOTH_SEQ_TIMEOUT_EN is defined.
module tb_booth_mult_sequencer;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_x, in_y;
  logic           mul_start;
  logic [W-1:0]   mul_x, mul_y;
  logic [2*W-1:0] mul_z;
  logic           mul_valid;
  logic           out_valid, out_ready;
  logic [2*W-1:0] out_z;
  logic [W-1:0]   out_x, out_y;
  logic           busy;
`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic           err_timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  bit mul_dis  = 1'b0;
  logic [4*W-1:0] res_q[$];

  always #5 clk = ~clk;

  booth_mult_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_z(mul_z), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x), .out_y(out_y),
`ifdef BOOTH_SEQ_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .busy(busy)
  );

  // Multiplier model: drops valid on start, raises it with the product 3 edges later, holds it.
  logic [2:0] mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_z     <= '0;
      mcnt      <= '0;
    end else if (mul_start) begin
      mul_valid <= 1'b0;
      mcnt      <= 3'd3;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 3'd1;
      if (mcnt == 3'd1 && !mul_dis) begin
        mul_valid <= 1'b1;
        mul_z     <= {{W{mul_x[W-1]}}, mul_x} * {{W{mul_y[W-1]}}, mul_y};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  bit mv_d1 = 1'b0, mv_d2 = 1'b0, ov_d1 = 1'b0;
  always @(negedge clk) begin
    if (mul_start) n_start++;
    if (out_valid && out_ready) res_q.push_back({out_z, out_x, out_y});
    if (out_valid && !ov_d1 && !mul_dis)
      check("valid_latency", {30'b0, mv_d2, mv_d1}, 32'b01);
    mv_d2 = mv_d1;
    mv_d1 = mul_valid;
    ov_d1 = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    for (int k = 0; k < 100 && !in_ready; k++) step();
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 300 && res_q.size() < n; k++) step();
    check("result_count", res_q.size(), n);
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      step();
      cycles++;
    end
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic check_res(input string name, input logic [2*W-1:0] z, input logic [W-1:0] x,
                           input logic [W-1:0] y);
    logic [4*W-1:0] r;
    if (res_q.size() == 0) begin
      check({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      check({name, "_z"}, r[4*W-1:2*W], z);
      check({name, "_x"}, r[2*W-1:W], x);
      check({name, "_y"}, r[W-1:0], y);
    end
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] z;
  } vec_t;

  vec_t vecs[8];
  int   st0, cyc;

  initial begin
    vecs[0] = '{x: 4'h4, y: 4'h3, z: 8'h0C};  //  4 *  3 =  12
    vecs[1] = '{x: 4'hB, y: 4'h2, z: 8'hF6};  // -5 *  2 = -10
    vecs[2] = '{x: 4'hD, y: 4'hD, z: 8'h09};  // -3 * -3 =   9
    vecs[3] = '{x: 4'h7, y: 4'hC, z: 8'hE4};  //  7 * -4 = -28
    vecs[4] = '{x: 4'h8, y: 4'h8, z: 8'h40};  // -8 * -8 =  64
    vecs[5] = '{x: 4'h8, y: 4'h7, z: 8'hC8};  // -8 *  7 = -56
    vecs[6] = '{x: 4'h0, y: 4'h5, z: 8'h00};  //  0 *  5 =   0
    vecs[7] = '{x: 4'hF, y: 4'hF, z: 8'h01};  // -1 * -1 =   1

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    step(); step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mul_start", {31'b0, mul_start}, 32'd0);
    check("rst_outs", {out_z, out_x, out_y, mul_x, mul_y}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      push_one(vecs[i].x, vecs[i].y);
      in_valid = 1'b0;
      if (i == 0) begin
        check("pre_start", {31'b0, mul_start}, 32'd0);
        step();
        check("start_hi", {31'b0, mul_start}, 32'd1);
        check("start_mul_x", mul_x, vecs[i].x);
        check("start_mul_y", mul_y, vecs[i].y);
        step();
        check("start_lo", {31'b0, mul_start}, 32'd0);
        check("hold_mul_x", mul_x, vecs[i].x);
      end
      wait_results(1);
      check_res($sformatf("vec%0d", i), vecs[i].z, vecs[i].x, vecs[i].y);
      step();
    end
    check("vec_starts", n_start, 8);

    // Streaming: five pairs back to back, FIFO fills while the first op waits
    st0 = n_start;
    for (int i = 3; i < 8; i++) push_one(vecs[i].x, vecs[i].y);
    check("stream_full", {31'b0, in_ready}, 32'd0);
    check("stream_busy", {31'b0, busy}, 32'd1);
    in_valid = 1'b0;
    wait_results(5);
    for (int i = 3; i < 8; i++)
      check_res($sformatf("stream%0d", i), vecs[i].z, vecs[i].x, vecs[i].y);
    step(); step();
    check("stream_starts", n_start - st0, 5);
    check("stream_idle", {31'b0, busy}, 32'd0);

    // Backpressure: hold the first result for 10 cycles with a second op queued
    out_ready = 1'b0;
    push_one(4'h3, 4'h5);
    push_one(4'hE, 4'h6);
    in_valid = 1'b0;
    wait_out_valid(cyc);
    st0 = n_start;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_z", out_z, 8'h0F);
      check("hold_xy", {out_x, out_y}, 8'h35);
    end
    check("hold_no_start", n_start - st0, 0);
    out_ready = 1'b1;
    wait_results(2);
    check_res("hold_first", 8'h0F, 4'h3, 4'h5);
    check_res("hold_second", 8'hF4, 4'hE, 4'h6);  // -2 * 6 = -12
    check("hold_starts", n_start - st0, 1);
    step();

    // Reset while the first op waits and two more are queued
    push_one(4'h2, 4'h2);
    push_one(4'h3, 4'h3);
    push_one(4'h4, 4'h4);
    in_valid = 1'b0;
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_valid_start", {30'b0, out_valid, mul_start}, 32'd0);
    check("mid_rst_outs", {out_z, out_x, out_y, mul_x, mul_y}, 32'd0);
    step();
    rst = 1'b0;
    st0 = n_start;
    for (int k = 0; k < 30; k++) step();
    check("mid_rst_no_results", res_q.size(), 0);
    check("mid_rst_no_start", n_start - st0, 0);
    check("mid_rst_idle", {31'b0, busy}, 32'd0);

`ifdef BOOTH_SEQ_TIMEOUT_EN
    // Watchdog: multiplier never completes
    check("to_err_clear", {31'b0, err_timeout}, 32'd0);
    mul_dis = 1'b1;
    out_ready = 1'b0;
    push_one(4'h2, 4'h3);
    in_valid = 1'b0;
    step();
    check("to_start", {31'b0, mul_start}, 32'd1);
    wait_out_valid(cyc);
    check("to_cycles", cyc, 33);
    check("to_err", {31'b0, err_timeout}, 32'd1);
    check("to_z", out_z, 8'h00);
    check("to_xy", {out_x, out_y}, 8'h23);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("to_sticky", {31'b0, err_timeout}, 32'd1);
    check_res("to_res", 8'h00, 4'h2, 4'h3);
    mul_dis = 1'b0;
    rst = 1'b1;
    step();
    check("to_rst_clear", {31'b0, err_timeout}, 32'd0);
    rst = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
